// File: rtl/spram_stream_fifo.sv
// rtl/spram_stream_fifo.sv - ready/valid FIFO on one up5k SPRAM (16-bit x 16K) with a 2-entry registered output buffer
module spram_stream_fifo #(
  parameter int WIDTH       = 8,
  parameter int ADDR_BITS   = 15,
  parameter int AFULL_LEVEL = 2**ADDR_BITS - 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_BITS+1:0] count,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full
);
  localparam int WORD_BITS = (WIDTH == 8) ? ADDR_BITS - 1 : ADDR_BITS;
  localparam int WORDS = 2**WORD_BITS;
  localparam logic [ADDR_BITS:0]   DEPTH   = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0]   CNT_ONE = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] PTR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  generate
    if (WIDTH != 8 && WIDTH != 16) begin : g_bad_width
      $error("spram_stream_fifo: WIDTH must be 8 or 16");
    end
    if (ADDR_BITS < ((WIDTH == 8) ? 2 : 1) || ADDR_BITS > ((WIDTH == 8) ? 15 : 14)) begin : g_bad_addr
      $error("spram_stream_fifo: ADDR_BITS out of range for WIDTH");
    end
  endgenerate

  typedef enum logic {PRIO_WRITE = 1'b0, PRIO_READ = 1'b1} prio_e;

  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   mem_count_q, mem_count_d;
  logic                 inflight_q, inflight_d;
  logic [1:0]           buf_count_q, buf_count_d;
  logic [WIDTH-1:0]     buf0_q, buf0_d, buf1_q, buf1_d;
  prio_e                prio_q, prio_d;

  logic                 pop, write_req, fetch_req, do_write, do_fetch;
  logic [2:0]           buf_after_pop;
  logic [WORD_BITS-1:0] wr_addr, rd_addr, mem_addr;
  logic [3:0]           wr_mask;
  logic [15:0]          mem_wdata, mem_rdata_q;
  logic [WIDTH-1:0]     rd_lane;
  logic [15:0]          mem [WORDS];

  assign full      = (mem_count_q == DEPTH);
  assign pop       = (buf_count_q != 2'd0) && out_ready;
  // A same-cycle pop frees a slot, which keeps the drain at one word per cycle.
  assign buf_after_pop = {1'b0, buf_count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign write_req = in_valid && !full;
  assign fetch_req = (mem_count_q != '0) && (buf_after_pop < 3'd2);
  assign in_ready  = !reset && !full && !(fetch_req && prio_q == PRIO_READ);
  assign do_write  = in_valid && in_ready;
  assign do_fetch  = fetch_req && !do_write && !reset;
  assign mem_addr  = do_write ? wr_addr : rd_addr;

  generate
    if (WIDTH == 8) begin : g_byte
      logic lane_q, lane_d;
      assign wr_addr   = wr_ptr_q[ADDR_BITS-1:1];
      assign rd_addr   = rd_ptr_q[ADDR_BITS-1:1];
      assign wr_mask   = wr_ptr_q[0] ? 4'b1100 : 4'b0011;
      assign mem_wdata = {in_data, in_data};
      assign rd_lane   = lane_q ? mem_rdata_q[15:8] : mem_rdata_q[7:0];
      always_comb lane_d = do_fetch ? rd_ptr_q[0] : lane_q;
      always_ff @(posedge clk) lane_q <= lane_d;
    end else begin : g_half
      assign wr_addr   = wr_ptr_q;
      assign rd_addr   = rd_ptr_q;
      assign wr_mask   = 4'b1111;
      assign mem_wdata = in_data;
      assign rd_lane   = mem_rdata_q;
    end
  endgenerate

  // Single-port array with nibble write mask and registered read, as SB_SPRAM256KA behaves.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i]) mem[mem_addr][4*i +: 4] <= mem_wdata[4*i +: 4];
      end
    end else if (do_fetch) begin
      mem_rdata_q <= mem[mem_addr];
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    inflight_d  = do_fetch;
    prio_d      = prio_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    buf_count_d = buf_count_q;
    if (do_write) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_fetch) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_write && !do_fetch) mem_count_d = mem_count_q + CNT_ONE;
    if (do_fetch && !do_write) mem_count_d = mem_count_q - CNT_ONE;
    if (write_req && fetch_req) prio_d = (prio_q == PRIO_WRITE) ? PRIO_READ : PRIO_WRITE;
    if (pop) begin
      buf0_d      = buf1_q;
      buf_count_d = buf_count_q - 2'd1;
    end
    if (inflight_q) begin
      if (buf_count_d == 2'd0) buf0_d = rd_lane;
      else                     buf1_d = rd_lane;
      buf_count_d = buf_count_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      inflight_q  <= 1'b0;
      prio_q      <= PRIO_WRITE;
      buf0_q      <= '0;
      buf1_q      <= '0;
      buf_count_q <= 2'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      inflight_q  <= inflight_d;
      prio_q      <= prio_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      buf_count_q <= buf_count_d;
    end
  end

  assign count       = {1'b0, mem_count_q} + {{(ADDR_BITS+1){1'b0}}, inflight_q}
                     + {{ADDR_BITS{1'b0}}, buf_count_q};
  assign empty       = (count == '0);
  assign almost_full = int'(count) >= AFULL_LEVEL;
  assign out_valid   = (buf_count_q != 2'd0);
  assign out_data    = buf0_q;
endmodule

// File: tb/tb_spram_stream_fifo.sv
// tb/tb_spram_stream_fifo.sv - scoreboard bench for spram_stream_fifo (16-bit/4-bit-addr and 8-bit/4-bit-addr instances)
module tb_spram_stream_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        a_reset, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:0] a_in_data, a_out_data;
  logic [5:0]  a_count;
  logic        a_empty, a_full, a_afull;

  logic        b_reset, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_in_data, b_out_data;
  logic [5:0]  b_count;
  logic        b_empty, b_full, b_afull;

  spram_stream_fifo #(.WIDTH(16), .ADDR_BITS(4), .AFULL_LEVEL(12)) dut_a (
    .clk(clk), .reset(a_reset), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .count(a_count),
    .empty(a_empty), .full(a_full), .almost_full(a_afull));

  spram_stream_fifo #(.WIDTH(8), .ADDR_BITS(4), .AFULL_LEVEL(12)) dut_b (
    .clk(clk), .reset(b_reset), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .count(b_count),
    .empty(b_empty), .full(b_full), .almost_full(b_afull));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: an ideal FIFO is a queue; occupancy is accepted minus popped.
  logic [15:0] a_exp[$];
  logic [7:0]  b_exp[$];
  int a_occ = 0, a_pops = 0, a_accs = 0;
  int b_occ = 0, b_pops = 0;

  task automatic a_cycle(input logic v, input logic [15:0] d, input logic r, output logic acc);
    @(negedge clk);
    a_in_valid = v; a_in_data = d; a_out_ready = r;
    #1;
    acc = v && a_in_ready;
    if (acc) begin a_exp.push_back(d); a_accs++; end
  endtask

  task automatic b_cycle(input logic v, input logic [7:0] d, input logic r, output logic acc);
    @(negedge clk);
    b_in_valid = v; b_in_data = d; b_out_ready = r;
    #1;
    acc = v && b_in_ready;
    if (acc) b_exp.push_back(d);
  endtask

  always @(negedge clk) begin
    #4;
    if (a_reset) begin
      a_occ = 0;
      a_exp.delete();
    end else begin
      check("a_count", 32'(a_count), 32'(a_occ));
      check("a_empty", 32'(a_empty), 32'(a_occ == 0));
      if (a_out_valid && a_out_ready) begin
        if (a_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_out: got 0x%0h, expected no output", a_out_data);
        end else begin
          check("a_out_data", 32'(a_out_data), 32'(a_exp.pop_front()));
        end
        a_pops++; a_occ--;
      end
      if (a_in_valid && a_in_ready) a_occ++;
    end
  end

  always @(negedge clk) begin
    #4;
    if (b_reset) begin
      b_occ = 0;
      b_exp.delete();
    end else begin
      check("b_count", 32'(b_count), 32'(b_occ));
      if (b_out_valid && b_out_ready) begin
        if (b_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_out: got 0x%0h, expected no output", b_out_data);
        end else begin
          check("b_out_data", 32'(b_out_data), 32'(b_exp.pop_front()));
        end
        b_pops++; b_occ--;
      end
      if (b_in_valid && b_in_ready) b_occ++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic acc, prev;
    int n, t, cmax, viol, a0, p0;
    a_reset = 1'b1; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_reset = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("in_ready_in_reset", 32'(a_in_ready), 32'(0));
    @(negedge clk); a_reset = 1'b0; #1;
    check("rst_empty", 32'(a_empty), 32'(1));
    check("rst_count", 32'(a_count), 32'(0));
    check("rst_out_valid", 32'(a_out_valid), 32'(0));
    check("rst_out_data", 32'(a_out_data), 32'(0));
    check("rst_in_ready", 32'(a_in_ready), 32'(1));
    check("rst_full", 32'(a_full), 32'(0));
    check("rst_afull", 32'(a_afull), 32'(0));

    // Write into an empty FIFO: visible three edges after acceptance.
    a_cycle(1'b1, 16'h00A5, 1'b0, acc); check("lat_accept", 32'(acc), 32'(1));
    a_cycle(1'b0, 16'h0, 1'b0, acc);   check("lat_e1_valid", 32'(a_out_valid), 32'(0));
    a_cycle(1'b0, 16'h0, 1'b0, acc);   check("lat_e2_valid", 32'(a_out_valid), 32'(0));
    a_cycle(1'b0, 16'h0, 1'b0, acc);   check("lat_e3_valid", 32'(a_out_valid), 32'(1));
    check("lat_data", 32'(a_out_data), 32'(16'h00A5));
    check("lat_count", 32'(a_count), 32'(1));
    a_cycle(1'b0, 16'h0, 1'b1, acc);
    a_cycle(1'b0, 16'h0, 1'b0, acc);

    // Fill to capacity: 16 in SPRAM + 2 in the output buffer.
    n = 0;
    repeat (30) begin a_cycle(1'b1, 16'($urandom), 1'b0, acc); n += int'(acc); end
    check("full_accepted", 32'(n), 32'(18));
    check("full_count", 32'(a_count), 32'(18));
    check("full_flag", 32'(a_full), 32'(1));
    check("full_in_ready", 32'(a_in_ready), 32'(0));
    check("full_afull", 32'(a_afull), 32'(1));
    a_cycle(1'b1, 16'($urandom), 1'b1, acc); check("full_pop_no_accept", 32'(acc), 32'(0));
    n = 0;
    repeat (2) begin a_cycle(1'b1, 16'($urandom), 1'b0, acc); n += int'(acc); end
    check("in_ready_recovers", 32'(n), 32'(1));
    a_cycle(1'b0, 16'h0, 1'b0, acc);
    check("refull_count", 32'(a_count), 32'(18));
    p0 = a_pops;
    repeat (18) a_cycle(1'b0, 16'h0, 1'b1, acc);
    a_cycle(1'b0, 16'h0, 1'b0, acc);
    check("drain_rate", 32'(a_pops - p0), 32'(18));
    check("drain_empty", 32'(a_empty), 32'(1));

    // Both sides streaming: grants alternate, each side near half rate.
    a0 = a_accs; p0 = a_pops; cmax = 0; prev = 1'b0; viol = 0;
    for (int i = 0; i < 100; i++) begin
      a_cycle(1'b1, 16'($urandom), 1'b1, acc);
      if (i >= 3 && acc && prev) viol++;
      prev = acc;
      if (int'(a_count) > cmax) cmax = int'(a_count);
    end
    check("stream_alternate", 32'(viol), 32'(0));
    check("stream_write_rate", 32'((a_accs - a0) >= 47 && (a_accs - a0) <= 53), 32'(1));
    check("stream_read_rate", 32'((a_pops - p0) >= 44 && (a_pops - p0) <= 52), 32'(1));
    check("stream_count_bound", 32'(cmax <= 4), 32'(1));
    repeat (10) a_cycle(1'b0, 16'h0, 1'b1, acc);
    check("stream_drained", 32'(a_empty), 32'(1));

    // 40 interleaved words across the pointer wrap.
    n = 0; t = 0; p0 = a_pops;
    while (n < 40 && t < 400) begin
      a_cycle(($urandom % 2) == 1, 16'h4000 + 16'(n), ($urandom % 2) == 1, acc);
      n += int'(acc); t++;
    end
    check("wrap_accepted", 32'(n), 32'(40));
    repeat (30) a_cycle(1'b0, 16'h0, 1'b1, acc);
    check("wrap_popped", 32'(a_pops - p0), 32'(40));
    check("wrap_empty", 32'(a_empty), 32'(1));

    // Reset with a fetch in flight and a word buffered.
    a_cycle(1'b1, 16'h1111, 1'b0, acc);
    t = 0;
    do begin a_cycle(1'b1, 16'h2222, 1'b0, acc); t++; end while (!acc && t < 5);
    t = 0;
    do begin a_cycle(1'b0, 16'h0, 1'b0, acc); t++; end while (!a_out_valid && t < 10);
    check("rst_setup_valid", 32'(a_out_valid), 32'(1));
    check("rst_setup_count", 32'(a_count), 32'(2));
    @(negedge clk);
    a_reset = 1'b1; a_in_valid = 1'b1; a_in_data = 16'hDEAD; a_out_ready = 1'b0;
    #1 check("in_ready_during_reset", 32'(a_in_ready), 32'(0));
    @(negedge clk);
    a_reset = 1'b0; a_in_valid = 1'b0;
    #1;
    check("midrst_count", 32'(a_count), 32'(0));
    check("midrst_out_valid", 32'(a_out_valid), 32'(0));
    a_cycle(1'b1, 16'h1234, 1'b0, acc); check("midrst_accept", 32'(acc), 32'(1));
    t = 0;
    do begin a_cycle(1'b0, 16'h0, 1'b0, acc); t++; end while (!a_out_valid && t < 10);
    check("midrst_latency", 32'(t), 32'(3));
    check("midrst_first_out", 32'(a_out_data), 32'(16'h1234));
    a_cycle(1'b0, 16'h0, 1'b1, acc);
    a_cycle(1'b0, 16'h0, 1'b0, acc);

    // Byte-wide instance: fill/drain then a long random stream through all byte values.
    @(negedge clk); b_reset = 1'b0;
    n = 0;
    repeat (30) begin b_cycle(1'b1, 8'(n), 1'b0, acc); n += int'(acc); end
    check("b_fill", 32'(n), 32'(18));
    check("b_full", 32'(b_full), 32'(1));
    p0 = b_pops;
    repeat (18) b_cycle(1'b0, 8'h0, 1'b1, acc);
    b_cycle(1'b0, 8'h0, 1'b0, acc);
    check("b_drain_rate", 32'(b_pops - p0), 32'(18));
    check("b_drain_empty", 32'(b_empty), 32'(1));
    t = 0;
    while (n < 300 && t < 3000) begin
      b_cycle(($urandom % 3) != 0, 8'(n), ($urandom % 3) != 0, acc);
      n += int'(acc); t++;
    end
    check("b_stream_accepted", 32'(n), 32'(300));
    repeat (30) b_cycle(1'b0, 8'h0, 1'b1, acc);
    check("b_total_popped", 32'(b_pops), 32'(300));
    check("b_final_empty", 32'(b_empty), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
